load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Initiator side of the data-memory interface.
- Accepts one load/store at a time from the execute stage and drives the word-addressed data memory: word address, write enable, write data, combinational read data.
- Sub-word stores are done as a single-cycle read-modify-write: the memory has no byte enables.
- Handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW alignment, sign/zero extension and access-fault detection; returns one response per request.

Parameters:
- ADDRESS_WIDTH, 6, memory word-address width (depth = 1<<ADDRESS_WIDTH words).
- DATA_WIDTH, 32, memory word width; fixed at 32 for RV32I.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request offered.
- req_ready  output  1  LSU can accept a request.
- req_we  input  1  1=store, 0=load.
- req_funct3  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result, extended; 0 for stores.
- rsp_err  output  1  misaligned, out-of-range or illegal funct3.
- mem_write_en  output  1  memory write strobe.
- mem_address  output  ADDRESS_WIDTH  word address.
- mem_write_data  output  DATA_WIDTH  merged write word.
- mem_read_data  input  DATA_WIDTH  combinational read of mem_address.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_write_en=0; mem_address=0; mem_write_data=0.
- Request registers: request fields are registered on acceptance (req_valid & req_ready).
- req_ready is 1 only in IDLE.
- States: IDLE, ACCESS0, ACCESS1 (split only), RESP.
- IDLE: on accept, go to ACCESS0, unless a fault is detected; a fault goes straight to RESP with rsp_err=1.
  - Fault conditions: funct3 illegal (011, 110, 111, or 1xx with req_we=1); req_addr[31:ADDRESS_WIDTH+2] != 0; misaligned (H with addr[0]=1, W with addr[1:0]!=0) when the split feature is absent.
  - A faulting access produces no memory write.
- ACCESS0: mem_address = addr[ADDRESS_WIDTH+1:2].
  - Load: capture the lanes of mem_read_data.
  - Store: mem_write_en=1 and mem_write_data = mem_read_data with the target bytes replaced by req_wdata lanes (shifted by addr[1:0]); word stores replace all bytes.
  - Next state is ACCESS1 if the access crosses a word, else RESP.
- ACCESS1: mem_address = word+1. Same capture or RMW for the remaining bytes. Word wrap past the last word is a fault, detected in IDLE.
- RESP: rsp_valid=1 for exactly one cycle; rsp_rdata/rsp_err hold until the next RESP. Then go to IDLE.
- Latency: accept to rsp_valid is 2 cycles (aligned), 3 cycles (split), 1 cycle (fault).
- Extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend.
- mem_write_en is 0 in every state except a store's ACCESS0/ACCESS1.
- rst_n asserted mid-access: everything aborts immediately, no response is produced, and mem_write_en drops asynchronously.
  - A write already clocked at an earlier edge stands; a partially completed split store may leave the first word written.
- A request presented during RESP is not accepted (req_ready=0); it is taken in the following IDLE cycle.

Optional Feature:
- Macro: LSU_MISALIGNED_SPLIT_EN.
- Defined: misaligned H/W accesses are split into two word accesses (ACCESS0/ACCESS1) and complete without error.
- Undefined: ACCESS1 is absent; misaligned accesses return rsp_err=1 with no memory access, after 1 cycle.

Decomposition:
- Package common gets:
  - typedef enum logic [2:0] mem_funct3_e (MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU);
  - typedef enum lsu_state_e (IDLE, ACCESS0, ACCESS1, RESP);
  - const int XLEN = 32.
- One combinational sub-module, lsu_data_align:
  - store side: byte-lane merge for RMW given offset, size and old word;
  - load side: lane extraction plus sign/zero extension.
- The FSM and the registers stay in load_store_unit.

Test Plan:
- Preload word 3 = 0x8899AABB; LB addr 0x0C -> rsp_rdata=0xFFFFFFBB at accept+2; LBU addr 0x0E -> 0x00000099; LH addr 0x0E -> 0xFFFF8899.
- SB addr 0x0D data 0x11 over 0x8899AABB -> one mem_write_en pulse; word 3 = 0x889911BB; rsp_valid with rsp_err=0.
- LW addr 0x13, macro off -> rsp_err=1 one cycle after accept, no write. Macro on, words 4/5 = 0x44332211/0x88776655 -> rsp_rdata=0x77665544 at accept+3.
- SW addr 0x100 (out of range for ADDRESS_WIDTH=6) -> rsp_err=1, mem_write_en never asserts.
- Back-to-back: req_valid held for SW 0x20 then LW 0x20 -> second accept only after RESP; load returns the stored value.
- rst_n low during ACCESS0 of an SB -> req_ready=1, rsp_valid=0 immediately; no response pulse after rst_n rises.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit_pkg
//  Purpose  : Shared types and helpers for the load/store unit.
//  Revision : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS0 = 2'd1,
        ACCESS1 = 2'd2,
        RESP    = 2'd3
    } lsu_state_e;

    // Byte-lane mask of an access at offset 0, from funct3[1:0].
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_data_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_data_align
//  Purpose  : Byte-lane merge for read-modify-write stores and lane
//             extraction with sign/zero extension for loads.
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_data_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]        i_offset,
    input  logic [2:0]        i_funct3,
    input  logic              i_upper,
    input  logic [XLEN-1:0]   i_old_word,
    input  logic [XLEN-1:0]   i_wdata,
    output logic [XLEN-1:0]   o_merged,
    input  logic [2*XLEN-1:0] i_window,
    output logic [XLEN-1:0]   o_load_data
);

    localparam int c_BYTES = XLEN / 8;

    logic [2*XLEN-1:0]    w_wide_data;
    logic [2*c_BYTES-1:0] w_wide_mask;
    logic [XLEN-1:0]      w_lane_data;
    logic [c_BYTES-1:0]   w_lane_mask;
    logic [XLEN-1:0]      w_sel;

    // The access is viewed as a two-word window; i_upper picks the second word.
    assign w_wide_data = {{XLEN{1'b0}}, i_wdata} << {i_offset, 3'b000};
    assign w_wide_mask = {{c_BYTES{1'b0}}, size_mask(i_funct3[1:0])} << i_offset;
    assign w_lane_data = i_upper ? w_wide_data[2*XLEN-1:XLEN] : w_wide_data[XLEN-1:0];
    assign w_lane_mask = i_upper ? w_wide_mask[2*c_BYTES-1:c_BYTES] : w_wide_mask[c_BYTES-1:0];

    generate
        for (genvar i = 0; i < c_BYTES; i++) begin : g_lane
            assign o_merged[8*i +: 8] = w_lane_mask[i] ? w_lane_data[8*i +: 8]
                                                       : i_old_word[8*i +: 8];
        end
    endgenerate

    assign w_sel = i_window[{i_offset, 3'b000} +: XLEN];

    always_comb begin
        case (i_funct3)
            MEM_B:   o_load_data = {{(XLEN-8){w_sel[7]}}, w_sel[7:0]};
            MEM_H:   o_load_data = {{(XLEN-16){w_sel[15]}}, w_sel[15:0]};
            MEM_BU:  o_load_data = {{(XLEN-8){1'b0}}, w_sel[7:0]};
            MEM_HU:  o_load_data = {{(XLEN-16){1'b0}}, w_sel[15:0]};
            default: o_load_data = w_sel;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Data-memory initiator for RV32I loads/stores with RMW sub-word
//             stores. Define LSU_MISALIGNED_SPLIT_EN to split misaligned
//             accesses into two word accesses instead of faulting them.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     rsp_valid,
    output logic [31:0]              rsp_rdata,
    output logic                     rsp_err,
    output logic                     mem_write_en,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0]    mem_write_data,
    input  logic [DATA_WIDTH-1:0]    mem_read_data
);

    localparam logic [1:0] c_IDLE    = IDLE;
    localparam logic [1:0] c_ACCESS0 = ACCESS0;
    localparam logic [1:0] c_ACCESS1 = ACCESS1;
    localparam logic [1:0] c_RESP    = RESP;

    logic [1:0]               r_state;
    logic                     r_we;
    logic [2:0]               r_funct3;
    logic [ADDRESS_WIDTH-1:0] r_word;
    logic [1:0]               r_off;
    logic [DATA_WIDTH-1:0]    r_wdata;

    logic                     w_accept;
    logic                     w_is_h;
    logic                     w_is_w;
    logic                     w_f3_bad;
    logic                     w_range_bad;
    logic                     w_fault;
    logic                     w_upper;
    logic [2*DATA_WIDTH-1:0]  w_window;
    logic [DATA_WIDTH-1:0]    w_merged;
    logic [DATA_WIDTH-1:0]    w_load_data;
    logic [31:0]              w_rsp_data;

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic                     r_cross;
    logic [DATA_WIDTH-1:0]    r_lo;
    logic                     w_cross;
    logic                     w_wrap;
`endif

    assign req_ready = (r_state == c_IDLE);
    assign rsp_valid = (r_state == c_RESP);
    assign w_accept  = req_valid & req_ready;

    assign w_is_h      = (req_funct3[1:0] == 2'b01);
    assign w_is_w      = (req_funct3[1:0] == 2'b10);
    assign w_f3_bad    = ((req_funct3 != MEM_B)  && (req_funct3 != MEM_H) &&
                          (req_funct3 != MEM_W)  && (req_funct3 != MEM_BU) &&
                          (req_funct3 != MEM_HU)) || (req_funct3[2] && req_we);
    assign w_range_bad = |req_addr[31:ADDRESS_WIDTH+2];

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign w_cross = (w_is_h && (req_addr[1:0] == 2'b11)) ||
                     (w_is_w && (req_addr[1:0] != 2'b00));
    // A crossing access starting in the last word would wrap to word 0.
    assign w_wrap  = w_cross && (&req_addr[ADDRESS_WIDTH+1:2]);
    assign w_fault = w_f3_bad || w_range_bad || w_wrap;
`else
    assign w_fault = w_f3_bad || w_range_bad ||
                     (w_is_h && req_addr[0]) || (w_is_w && (req_addr[1:0] != 2'b00));
`endif

    assign w_upper        = (r_state == c_ACCESS1);
    assign mem_address    = w_upper ? (r_word + {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1}) : r_word;
    // Derived straight from state so an async reset drops the strobe at once.
    assign mem_write_en   = r_we && ((r_state == c_ACCESS0) || w_upper);
    assign mem_write_data = mem_write_en ? w_merged : '0;

`ifdef LSU_MISALIGNED_SPLIT_EN
    assign w_window = w_upper ? {mem_read_data, r_lo} : {{DATA_WIDTH{1'b0}}, mem_read_data};
`else
    assign w_window = {{DATA_WIDTH{1'b0}}, mem_read_data};
`endif

    assign w_rsp_data = r_we ? 32'd0 : w_load_data;

    lsu_data_align u_align (
        .i_offset    (r_off),
        .i_funct3    (r_funct3),
        .i_upper     (w_upper),
        .i_old_word  (mem_read_data),
        .i_wdata     (r_wdata),
        .o_merged    (w_merged),
        .i_window    (w_window),
        .o_load_data (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_we      <= 1'b0;
            r_funct3  <= 3'd0;
            r_word    <= '0;
            r_off     <= 2'd0;
            r_wdata   <= '0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            r_cross   <= 1'b0;
            r_lo      <= '0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_word   <= req_addr[ADDRESS_WIDTH+1:2];
                        r_off    <= req_addr[1:0];
                        r_wdata  <= req_wdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
                        r_cross  <= w_cross;
`endif
                        if (w_fault) begin
                            r_state   <= c_RESP;
                            rsp_rdata <= 32'd0;
                            rsp_err   <= 1'b1;
                        end else begin
                            r_state   <= c_ACCESS0;
                        end
                    end
                end
                c_ACCESS0: begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    r_lo <= mem_read_data;
                    if (r_cross) begin
                        r_state <= c_ACCESS1;
                    end else begin
                        r_state   <= c_RESP;
                        rsp_rdata <= w_rsp_data;
                        rsp_err   <= 1'b0;
                    end
`else
                    r_state   <= c_RESP;
                    rsp_rdata <= w_rsp_data;
                    rsp_err   <= 1'b0;
`endif
                end
                c_ACCESS1: begin
                    r_state   <= c_RESP;
                    rsp_rdata <= w_rsp_data;
                    rsp_err   <= 1'b0;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
